// File: rtl/rt_dma_pkg.sv
// ----------------------------------------------------------------------------
// rt_dma_pkg
//   Shared types and constants for the RT frame sequencer.
//   - rt_state_e : sequencer states (IDLE, HDR, STREAM, CSUM, DONE)
//   - HDR_MAGIC  : default header marker byte
//   - CSUM_EN    : 1 when the build includes the checksum trailer
//   - frame_len  : number of FIFO writes making up one frame
//   Build macro: RT_FRAME_CHECKSUM_EN (adds the checksum trailer word).
// ----------------------------------------------------------------------------
package rt_dma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        STREAM = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4
    } rt_state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

`ifdef RT_FRAME_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    // Header + payload, plus one trailer word when the checksum is built in.
    function automatic int unsigned frame_len(input int unsigned n, input bit csum);
        return n + 32'd1 + (csum ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/rt_frame_checksum.sv
// ----------------------------------------------------------------------------
// rt_frame_checksum
//   Modulo-2^DATA_W running sum of the words of one frame.
//   Build macro: RT_FRAME_CHECKSUM_EN (only instantiated when defined).
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   clear      in   1       restart the sum; combined with accumulate the
//                           sum restarts at din
//   accumulate in   1       add din into the sum this cycle
//   din        in   DATA_W  word to add
//   result     out  DATA_W  current sum
// ----------------------------------------------------------------------------
module rt_frame_checksum #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] base;

    always_comb begin
        base  = clear ? '0 : acc_q;
        acc_d = accumulate ? (base + din) : base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/rt_dma_frame_sequencer.sv
// ----------------------------------------------------------------------------
// rt_dma_frame_sequencer
//   Per RT-cycle tick, streams one frame (header, N_WORDS payload words and,
//   optionally, a checksum trailer) from the RT word bank into the PCIe DMA
//   FIFO. A frame is only started when the FIFO already has room for all of
//   it, so once started it is written with no gaps.
//   Build macro: RT_FRAME_CHECKSUM_EN (appends a modulo-2^32 checksum word).
//
// Ports
//   processing_clock in   1       clock, rising edge
//   PCIe_trn_rst_n   in   1       asynchronous active-low reset
//   rt_cycle_tick    in   1       one-cycle frame request
//   enable           in   1       0 = ticks ignored entirely
//   clear_status     in   1       clears drop_count and overrun
//   fifo_free_words  in   16      free FIFO entries
//   word_sel         out  SEL_W   payload index into the word bank
//   word_data        in   DATA_W  bank data, one cycle after word_sel
//   PCIe_rd_en       out  1       FIFO write strike
//   PCIe_rd_data     out  DATA_W  FIFO write data
//   busy             out  1       frame in progress
//   frame_count      out  32      completed frames (wraps)
//   drop_count       out  16      rejected ticks (saturates)
//   overrun          out  1       sticky: tick arrived while busy
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for an accepted tick
// HDR    | word_sel=0 presented, header registered onto the FIFO port
// STREAM | one payload word registered per cycle, word_sel running ahead
// CSUM   | checksum trailer registered (checksum build only)
// DONE   | strikes end, frame_count advances
// ----------------------------------------------------------------------------
module rt_dma_frame_sequencer
    import rt_dma_pkg::*;
#(
    parameter int unsigned N_WORDS   = 42,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SEL_W     = 6,
    parameter logic [7:0]  HDR_MAGIC = rt_dma_pkg::HDR_MAGIC
) (
    input  logic              processing_clock,
    input  logic              PCIe_trn_rst_n,
    input  logic              rt_cycle_tick,
    input  logic              enable,
    input  logic              clear_status,
    input  logic [15:0]       fifo_free_words,
    output logic [SEL_W-1:0]  word_sel,
    input  logic [DATA_W-1:0] word_data,
    output logic              PCIe_rd_en,
    output logic [DATA_W-1:0] PCIe_rd_data,
    output logic              busy,
    output logic [31:0]       frame_count,
    output logic [15:0]       drop_count,
    output logic              overrun
);

    localparam int unsigned     FRAME_LEN   = frame_len(N_WORDS, CSUM_EN);
    localparam logic [15:0]     FRAME_LEN_W = 16'(FRAME_LEN);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_WORDS - 1);
    localparam logic [SEL_W-1:0] SEL_FIRST  = (N_WORDS > 1) ? SEL_W'(1) : '0;
    localparam logic [7:0]      N_WORDS_B   = 8'(N_WORDS);

    rt_state_e         state_q, state_d;
    logic [SEL_W-1:0]  word_sel_q, word_sel_d;
    logic              rd_en_q, rd_en_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [7:0]        remain_q, remain_d;
    logic [31:0]       frame_count_q, frame_count_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              overrun_q, overrun_d;

    logic              tick_live;
    logic              accept;
    logic              drop_evt;
    logic              overrun_evt;
    logic [DATA_W-1:0] header;

    // The header carries the count of the frame being sent, i.e. frames
    // completed so far.
    assign header = DATA_W'({HDR_MAGIC, N_WORDS_B, frame_count_q[15:0]});

`ifdef RT_FRAME_CHECKSUM_EN
    logic              csum_clear;
    logic              csum_acc;
    logic [DATA_W-1:0] csum_din;
    logic [DATA_W-1:0] csum_result;

    // Sum restarts with the header, then collects each payload word as it
    // is registered; by CSUM the result covers the whole frame.
    assign csum_clear = (state_q == HDR);
    assign csum_acc   = (state_q == HDR) || (state_q == STREAM);
    assign csum_din   = csum_clear ? header : word_data;

    rt_frame_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk        (processing_clock),
        .rst_n      (PCIe_trn_rst_n),
        .clear      (csum_clear),
        .accumulate (csum_acc),
        .din        (csum_din),
        .result     (csum_result)
    );
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge processing_clock or negedge PCIe_trn_rst_n) begin
        if (!PCIe_trn_rst_n) begin
            state_q       <= IDLE;
            word_sel_q    <= '0;
            rd_en_q       <= 1'b0;
            rd_data_q     <= '0;
            remain_q      <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_sel_q    <= word_sel_d;
            rd_en_q       <= rd_en_d;
            rd_data_q     <= rd_data_d;
            remain_q      <= remain_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            overrun_q     <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        tick_live   = rt_cycle_tick & enable;
        accept      = tick_live && (state_q == IDLE) && (fifo_free_words >= FRAME_LEN_W);
        overrun_evt = tick_live && (state_q != IDLE);
        drop_evt    = tick_live && !accept;

        state_d       = state_q;
        word_sel_d    = '0;
        rd_en_d       = 1'b0;
        rd_data_d     = '0;
        remain_d      = remain_q;
        frame_count_d = frame_count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                rd_en_d    = 1'b1;
                rd_data_d  = header;
                word_sel_d = SEL_FIRST;
                remain_d   = N_WORDS_B;
                state_d    = STREAM;
            end
            STREAM: begin
                // word_sel runs one ahead of the captured word because the
                // bank answers a cycle later; it parks at 0 once the last
                // index has been issued.
                rd_en_d   = 1'b1;
                rd_data_d = word_data;
                remain_d  = remain_q - 8'd1;
                if ((word_sel_q != '0) && (word_sel_q != SEL_LAST)) begin
                    word_sel_d = word_sel_q + 1'b1;
                end
                if (remain_q == 8'd1) begin
`ifdef RT_FRAME_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end
            end
            CSUM: begin
`ifdef RT_FRAME_CHECKSUM_EN
                rd_en_d   = 1'b1;
                rd_data_d = csum_result;
`endif
                state_d = DONE;
            end
            DONE: begin
                frame_count_d = frame_count_q + 32'd1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear in the same cycle as a drop wins.
        if (clear_status) begin
            drop_count_d = '0;
            overrun_d    = 1'b0;
        end else begin
            drop_count_d = drop_count_q;
            if (drop_evt && (drop_count_q != 16'hFFFF)) begin
                drop_count_d = drop_count_q + 16'd1;
            end
            overrun_d = overrun_q | overrun_evt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state_q != IDLE);
        word_sel     = word_sel_q;
        PCIe_rd_en   = rd_en_q;
        PCIe_rd_data = rd_data_q;
        frame_count  = frame_count_q;
        drop_count   = drop_count_q;
        overrun      = overrun_q;
    end

endmodule

// File: tb/tb_rt_dma_frame_sequencer.sv
module tb_rt_dma_frame_sequencer;

    localparam int N_WORDS = 42;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 6;
`ifdef RT_FRAME_CHECKSUM_EN
    localparam int FLEN     = N_WORDS + 2;
    localparam bit HAS_CSUM = 1'b1;
`else
    localparam int FLEN     = N_WORDS + 1;
    localparam bit HAS_CSUM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rt_cycle_tick;
    logic              enable;
    logic              clear_status;
    logic [15:0]       fifo_free_words;
    logic [SEL_W-1:0]  word_sel;
    logic [DATA_W-1:0] word_data;
    logic              PCIe_rd_en;
    logic [DATA_W-1:0] PCIe_rd_data;
    logic              busy;
    logic [31:0]       frame_count;
    logic [15:0]       drop_count;
    logic              overrun;

    always #5 clk = ~clk;

    rt_dma_frame_sequencer #(
        .N_WORDS   (N_WORDS),
        .DATA_W    (DATA_W),
        .SEL_W     (SEL_W),
        .HDR_MAGIC (8'hA5)
    ) dut (
        .processing_clock (clk),
        .PCIe_trn_rst_n   (rst_n),
        .rt_cycle_tick    (rt_cycle_tick),
        .enable           (enable),
        .clear_status     (clear_status),
        .fifo_free_words  (fifo_free_words),
        .word_sel         (word_sel),
        .word_data        (word_data),
        .PCIe_rd_en       (PCIe_rd_en),
        .PCIe_rd_data     (PCIe_rd_data),
        .busy             (busy),
        .frame_count      (frame_count),
        .drop_count       (drop_count),
        .overrun          (overrun)
    );

    // RT word bank: registered read, data one cycle after the index.
    logic [DATA_W-1:0] bank [64];
    always @(posedge clk) word_data <= bank[word_sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] fc_m;
    logic [15:0] drop_m;
    logic        ov_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strike capture and per-cycle history
    logic [DATA_W-1:0] cap_q [$];
    int                cap_cyc [$];
    logic              busy_h [int];
    logic [SEL_W-1:0]  sel_h [int];

    always @(negedge clk) begin
        if (PCIe_rd_en) begin
            cap_q.push_back(PCIe_rd_data);
            cap_cyc.push_back(cyc);
        end else begin
            chk("idle_data_zero", PCIe_rd_data, 0);
        end
        if (!busy) chk("idle_sel_zero", word_sel, 0);
        busy_h[cyc] = busy;
        sel_h[cyc]  = word_sel;
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] d);
        return (d == 16'hFFFF) ? d : d + 16'd1;
    endfunction

    function automatic logic [31:0] hdr_word(input logic [31:0] count);
        return {8'hA5, 8'(N_WORDS), count[15:0]};
    endfunction

    // Pulse the tick in cycle 'target' (or the next reachable cycle).
    task automatic tick_at(input int target, input logic with_clear, output int t);
        while (cyc + 1 < target) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rt_cycle_tick = 1'b1;
        clear_status  = with_clear;
        t = cyc;
        @(posedge clk); #1;
        rt_cycle_tick = 1'b0;
        clear_status  = 1'b0;
    endtask

    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
        @(negedge clk);
    endtask

    // Frame accepted with tick in cycle t: header at t+2, word i at t+3+i,
    // busy over t+1 .. t+FLEN+1, word_sel = k in cycle t+1+k.
    task automatic check_frame(input int t, input logic [31:0] count, input string tag);
        logic [DATA_W-1:0] exp [$];
        logic [DATA_W-1:0] sum;
        exp.push_back(hdr_word(count));
        for (int i = 0; i < N_WORDS; i++) exp.push_back(bank[i]);
        if (HAS_CSUM) begin
            sum = '0;
            foreach (exp[i]) sum = sum + exp[i];
            exp.push_back(sum);
        end
        chk({tag, "_strikes"}, (cap_q.size() >= exp.size()), 1);
        for (int i = 0; i < exp.size() && i < cap_q.size(); i++) begin
            chk({tag, "_data"}, cap_q[i], exp[i]);
            chk({tag, "_cycle"}, cap_cyc[i], t + 2 + i);
        end
        for (int i = 0; i < exp.size() && cap_q.size() > 0; i++) begin
            void'(cap_q.pop_front());
            void'(cap_cyc.pop_front());
        end
        chk({tag, "_busy_first"}, busy_h[t + 1], 1);
        chk({tag, "_busy_last"}, busy_h[t + FLEN + 1], 1);
        chk({tag, "_busy_after"}, busy_h[t + FLEN + 2], 0);
        for (int k = 0; k < N_WORDS; k++) chk({tag, "_word_sel"}, sel_h[t + 1 + k], k);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_frame_count"}, frame_count, fc_m);
        chk({tag, "_drop_count"}, drop_count, drop_m);
        chk({tag, "_overrun"}, overrun, ov_m);
        chk({tag, "_extra_strikes"}, cap_q.size(), 0);
        cap_q.delete();
        cap_cyc.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rd_en"}, PCIe_rd_en, 0);
        chk({tag, "_rd_data"}, PCIe_rd_data, 0);
        chk({tag, "_word_sel"}, word_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int t;
        int t2;
        rst_n           = 1'b0;
        rt_cycle_tick   = 1'b0;
        enable          = 1'b1;
        clear_status    = 1'b0;
        fifo_free_words = 16'd100;
        for (int i = 0; i < 64; i++) bank[i] = 32'h1000 + i;
        fc_m   = '0;
        drop_m = '0;
        ov_m   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, bank word i = 0x1000+i
        tick_at(cyc + 2, 1'b0, t);
        fifo_free_words = 16'd0;
        wait_neg(t + FLEN + 4);
        check_frame(t, fc_m, "basic");
        fc_m++;
        check_status("basic");

        // Not enough room: dropped, never busy
        fifo_free_words = 16'(FLEN - 1);
        tick_at(cyc + 2, 1'b0, t);
        drop_m = sat_inc(drop_m);
        wait_neg(t + 6);
        chk("nospace_busy1", busy_h[t + 1], 0);
        chk("nospace_busy3", busy_h[t + 3], 0);
        check_status("nospace");
        pulse_clear();
        drop_m = '0;
        check_status("nospace_clr");

        // Second tick 10 cycles into a frame
        fifo_free_words = 16'd100;
        tick_at(cyc + 2, 1'b0, t);
        fifo_free_words = 16'd0;
        tick_at(t + 10, 1'b0, t2);
        drop_m = sat_inc(drop_m);
        ov_m   = 1'b1;
        wait_neg(t + FLEN + 4);
        check_frame(t, fc_m, "overrun");
        fc_m++;
        check_status("overrun");
        pulse_clear();
        drop_m = '0;
        ov_m   = 1'b0;
        check_status("overrun_clr");

        // enable drops mid-frame: frame finishes, later tick ignored
        fifo_free_words = 16'd100;
        tick_at(cyc + 2, 1'b0, t);
        enable = 1'b0;
        tick_at(t + 10, 1'b0, t2);
        wait_neg(t + FLEN + 4);
        check_frame(t, fc_m, "enable_off");
        fc_m++;
        check_status("enable_off");
        enable = 1'b1;

        // Back-to-back: tick on the first idle cycle after DONE
        tick_at(cyc + 2, 1'b0, t);
        tick_at(t + FLEN + 2, 1'b0, t2);
        wait_neg(t2 + FLEN + 4);
        check_frame(t, fc_m, "b2b_first");
        fc_m++;
        check_frame(t2, fc_m, "b2b_second");
        fc_m++;
        check_status("b2b");

        // Clear together with a drop: clear wins
        fifo_free_words = 16'(FLEN - 1);
        tick_at(cyc + 2, 1'b0, t);
        drop_m = sat_inc(drop_m);
        fifo_free_words = 16'd100;
        tick_at(cyc + 2, 1'b0, t);
        fifo_free_words = 16'd0;
        tick_at(t + 6, 1'b1, t2);
        drop_m = '0;
        ov_m   = 1'b0;
        wait_neg(t + FLEN + 4);
        check_frame(t, fc_m, "clear_wins");
        fc_m++;
        check_status("clear_wins");

        // Randomized frames
        for (int it = 0; it < 12; it++) begin
            bit          en;
            bit          extra;
            bit          acc;
            int          off;
            logic [15:0] fv;
            for (int i = 0; i < 64; i++) bank[i] = $urandom;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) fv = 16'($urandom_range(FLEN - 2, FLEN + 1));
            else fv = 16'($urandom_range(0, 1000));
            extra = ($urandom_range(0, 1) == 1);
            off   = $urandom_range(2, FLEN);
            enable          = en;
            fifo_free_words = fv;
            tick_at(cyc + 2, 1'b0, t);
            acc = en && (int'(fv) >= FLEN);
            if (en && !acc) drop_m = sat_inc(drop_m);
            if (acc) begin
                fifo_free_words = 16'($urandom_range(0, FLEN - 1));
                if (extra) begin
                    tick_at(t + off, 1'b0, t2);
                    drop_m = sat_inc(drop_m);
                    ov_m   = 1'b1;
                end
            end
            wait_neg(t + FLEN + 4);
            if (acc) begin
                check_frame(t, fc_m, "rnd");
                fc_m++;
            end
            check_status("rnd");
            enable = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                pulse_clear();
                drop_m = '0;
                ov_m   = 1'b0;
            end
        end

        // Reset during payload word 20
        fifo_free_words = 16'd100;
        for (int i = 0; i < 64; i++) bank[i] = $urandom;
        tick_at(cyc + 2, 1'b0, t);
        wait_neg(t + 3 + 20);
        chk("midreset_pre_en", PCIe_rd_en, 1);
        chk("midreset_pre_data", PCIe_rd_data, bank[20]);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        cap_q.delete();
        cap_cyc.delete();
        fc_m   = '0;
        drop_m = '0;
        ov_m   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick_at(cyc + 2, 1'b0, t);
        wait_neg(t + FLEN + 4);
        check_frame(t, fc_m, "after_reset");
        fc_m++;
        check_status("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
